// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU issue scheduler: FSM states,
// instruction numbers understood by the execution element, operand bundle.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam logic [5:0] INST_ADD   = 6'd8;
    localparam logic [5:0] INST_ADDI  = 6'd9;
    localparam logic [5:0] INST_SUB   = 6'd10;
    localparam logic [5:0] INST_LUI   = 6'd11;
    localparam logic [5:0] INST_DIV   = 6'd12;
    localparam logic [5:0] INST_MULT  = 6'd13;
    localparam logic [5:0] INST_DIVI  = 6'd14;
    localparam logic [5:0] INST_MULTI = 6'd15;
    localparam logic [5:0] INST_SLL   = 6'd16;
    localparam logic [5:0] INST_SRA   = 6'd17;
    localparam logic [5:0] INST_SRL   = 6'd18;
    localparam logic [5:0] INST_AND   = 6'd20;
    localparam logic [5:0] INST_ANDI  = 6'd21;
    localparam logic [5:0] INST_OR    = 6'd22;
    localparam logic [5:0] INST_ORI   = 6'd23;
    localparam logic [5:0] INST_XOR   = 6'd24;
    localparam logic [5:0] INST_XORI  = 6'd25;
    localparam logic [5:0] INST_NOR   = 6'd26;

    typedef struct packed {
        logic [5:0]  inst_num;
        logic [31:0] const16_x;
        logic [4:0]  shift5;
        logic [31:0] rs;
        logic [31:0] rt;
    } operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the pointer
// and the first asserted request wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o,
    output logic               valid_o
);

    always_comb begin
        logic [ID_W-1:0] sel;
        logic            found;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        sel     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sel = ID_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                id_o         = sel;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one ALU execution element among NUM_REQ requesters: round-robin issue,
// operand latching, element reset/completion sequencing and a watchdog abort.
module alu_issue_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_W           = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*6-1:0]  req_inst_num,
    input  logic [NUM_REQ*32-1:0] req_const16_x,
    input  logic [NUM_REQ*5-1:0]  req_shift5,
    input  logic [NUM_REQ*32-1:0] req_rs,
    input  logic [NUM_REQ*32-1:0] req_rt,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_timeout,
    output logic                  elem_reset,
    input  logic                  elem_completed,
    output logic [5:0]            elem_inst_num,
    output logic [31:0]           elem_const16_x,
    output logic [4:0]            elem_shift5,
    output logic [31:0]           elem_rs,
    output logic [31:0]           elem_rt,
    input  logic [31:0]           elem_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    sched_state_e     state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [CNT_W-1:0] cnt_q;
    operand_t         op_q;
    logic             resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [31:0]      resp_data_q;
    logic             resp_timeout_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    operand_t           req_op [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_op[g] = {req_inst_num[6*g +: 6], req_const16_x[32*g +: 32],
                            req_shift5[5*g +: 5], req_rs[32*g +: 32], req_rt[32*g +: 32]};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (win_id),
        .valid_o (win_valid)
    );

    // Grants are only offered in IDLE, so an accept can never overlap an operation.
    assign req_ready = (state_q == IDLE) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= ID_W'(NUM_REQ - 1);
            cnt_q          <= '0;
            op_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        op_q      <= req_op[win_id];
                        resp_id_q <= win_id;
                        ptr_q     <= win_id;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (elem_completed) begin
                        resp_data_q    <= elem_out;
                        resp_timeout_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_q    <= '0;
                        resp_timeout_q <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Element is held in reset outside BUSY, so it restarts cleanly per operation.
    assign elem_reset     = reset | (state_q != BUSY);
    assign elem_inst_num  = op_q.inst_num;
    assign elem_const16_x = op_q.const16_x;
    assign elem_shift5    = op_q.shift5;
    assign elem_rs        = op_q.rs;
    assign elem_rt        = op_q.rt;

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: element stub, transaction-level reference
// model, per-cycle compare, directed scenarios and a randomized phase.
module tb_alu_issue_scheduler;
    import alu_sched_pkg::*;

    localparam int NR  = 2;
    localparam int IDW = 1;
    localparam int T   = 4;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*6-1:0]  req_inst_num;
    logic [NR*32-1:0] req_const16_x;
    logic [NR*5-1:0]  req_shift5;
    logic [NR*32-1:0] req_rs, req_rt;
    logic             resp_valid, resp_ready, resp_timeout;
    logic [IDW-1:0]   resp_id;
    logic [31:0]      resp_data;
    logic             elem_reset, elem_completed;
    logic [5:0]       elem_inst_num;
    logic [31:0]      elem_const16_x, elem_rs, elem_rt, elem_out;
    logic [4:0]       elem_shift5;

    logic        r_valid [NR];
    logic [5:0]  r_inst  [NR];
    logic [31:0] r_c     [NR];
    logic [4:0]  r_sh    [NR];
    logic [31:0] r_rs    [NR];
    logic [31:0] r_rt    [NR];

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0; req_inst_num = '0; req_const16_x = '0;
        req_shift5 = '0; req_rs = '0; req_rt = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]             = r_valid[i];
            req_inst_num[6*i +: 6]   = r_inst[i];
            req_const16_x[32*i +: 32] = r_c[i];
            req_shift5[5*i +: 5]     = r_sh[i];
            req_rs[32*i +: 32]       = r_rs[i];
            req_rt[32*i +: 32]       = r_rt[i];
        end
    end

    alu_issue_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inst_num(req_inst_num), .req_const16_x(req_const16_x),
        .req_shift5(req_shift5), .req_rs(req_rs), .req_rt(req_rt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_timeout(resp_timeout),
        .elem_reset(elem_reset), .elem_completed(elem_completed),
        .elem_inst_num(elem_inst_num), .elem_const16_x(elem_const16_x),
        .elem_shift5(elem_shift5), .elem_rs(elem_rs), .elem_rt(elem_rt),
        .elem_out(elem_out)
    );

    // Cycles the element needs after leaving reset; 0 marks the stuck unit (inst 7).
    function automatic int lat_of(logic [5:0] inst);
        case (inst)
            INST_MULT, INST_MULTI: return 2;
            INST_DIV, INST_DIVI:   return 3;
            6'd7:                  return 0;
            default:               return 1;
        endcase
    endfunction

    function automatic logic [31:0] sdiv(logic [31:0] a, logic [31:0] b);
        if (b == 32'd0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $unsigned($signed(a) / $signed(b));
    endfunction

    function automatic logic [31:0] alu_f(logic [5:0] inst, logic [31:0] c, logic [4:0] sh,
                                          logic [31:0] rs, logic [31:0] rt);
        case (inst)
            INST_ADD:   return rs + rt;
            INST_ADDI:  return rs + c;
            INST_SUB:   return rs - rt;
            INST_LUI:   return {c[15:0], 16'h0000};
            INST_DIV:   return sdiv(rs, rt);
            INST_DIVI:  return sdiv(rs, c);
            INST_MULT:  return rs * rt;
            INST_MULTI: return rs * c;
            INST_SLL:   return rt << sh;
            INST_SRA:   return $unsigned($signed(rt) >>> sh);
            INST_SRL:   return rt >> sh;
            INST_AND:   return rs & rt;
            INST_ANDI:  return rs & c;
            INST_OR:    return rs | rt;
            INST_ORI:   return rs | c;
            INST_XOR:   return rs ^ rt;
            INST_XORI:  return rs ^ c;
            INST_NOR:   return ~(rs | rt);
            default:    return rs;
        endcase
    endfunction

    // Element stub
    int st_cnt = 0;
    always @(posedge clk) begin
        if (elem_reset) st_cnt <= 0;
        else            st_cnt <= st_cnt + 1;
    end
    assign elem_completed = !elem_reset && (lat_of(elem_inst_num) > 0) &&
                            (st_cnt >= lat_of(elem_inst_num));
    assign elem_out = alu_f(elem_inst_num, elem_const16_x, elem_shift5, elem_rs, elem_rt);

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int pick(logic [NR-1:0] v, int ptr);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Reference model: an issued op yields its response a fixed number of
    // edges later (completion latency, capped by the watchdog).
    int          cyc = 0, m_done_at = 0, m_ptr = NR - 1;
    bit          m_busy = 0, m_rv = 0, m_to = 0, m_pend_to = 0;
    int          m_id = 0;
    logic [31:0] m_data = '0, m_pend_data = '0;
    operand_t    m_op = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; m_busy = 0; m_rv = 0; m_to = 0; m_id = 0;
            m_data = '0; m_op = '0; m_ptr = NR - 1;
        end else begin
            cyc++;
            if (m_rv) begin
                if (resp_ready) m_rv = 0;
            end else if (m_busy) begin
                if (cyc == m_done_at) begin
                    m_busy = 0; m_rv = 1; m_data = m_pend_data; m_to = m_pend_to;
                end
            end else begin
                int w, l;
                w = pick(req_valid, m_ptr);
                if (w >= 0) begin
                    m_op.inst_num  = req_inst_num[6*w +: 6];
                    m_op.const16_x = req_const16_x[32*w +: 32];
                    m_op.shift5    = req_shift5[5*w +: 5];
                    m_op.rs        = req_rs[32*w +: 32];
                    m_op.rt        = req_rt[32*w +: 32];
                    m_id = w; m_ptr = w; m_busy = 1;
                    l = lat_of(m_op.inst_num);
                    m_pend_to   = (l == 0) || (l + 1 > T);
                    m_pend_data = m_pend_to ? 32'd0 :
                                  alu_f(m_op.inst_num, m_op.const16_x, m_op.shift5, m_op.rs, m_op.rt);
                    m_done_at = cyc + (m_pend_to ? T : l + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [NR-1:0] e_rdy;
            int w;
            e_rdy = '0;
            w = pick(req_valid, m_ptr);
            if (!m_busy && !m_rv && w >= 0) e_rdy[w] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            chk("resp_valid", resp_valid, m_rv);
            chk("resp_id", resp_id, m_id);
            chk("resp_data", resp_data, m_data);
            chk("resp_timeout", resp_timeout, m_to);
            chk("elem_reset", elem_reset, !m_busy);
            chk("elem_ops", {elem_inst_num, elem_const16_x, elem_shift5, elem_rs, elem_rt},
                {m_op.inst_num, m_op.const16_x, m_op.shift5, m_op.rs, m_op.rt});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_req(input int i, input logic [5:0] inst, input logic [31:0] c,
                           input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt);
        r_valid[i] = 1'b1; r_inst[i] = inst; r_c[i] = c; r_sh[i] = sh; r_rs[i] = rs; r_rt[i] = rt;
    endtask

    int ops_tbl [22] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18,
                         20, 21, 22, 23, 24, 25, 26, 3, 40, 7, 8};

    initial begin
        int g [4];
        int ng;
        logic [NR-1:0] acc;

        reset = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            r_valid[i] = 1'b0; r_inst[i] = '0; r_c[i] = '0; r_sh[i] = '0; r_rs[i] = '0; r_rt[i] = '0;
        end
        @(posedge clk); #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_timeout", resp_timeout, 0);
        chk("rst_elem_reset", elem_reset, 1);
        chk("rst_elem_rs", elem_rs, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        tick(1);

        // ADD 3+4 from requester 0
        set_req(0, INST_ADD, 0, 0, 3, 4);
        #3 chk("t1_ready", req_ready, 2'b01);
        @(posedge clk); #2 r_valid[0] = 1'b0;
        @(posedge clk); #1 chk("t1_early", resp_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid", resp_valid, 1);
        chk("t1_data", resp_data, 7);
        chk("t1_id", resp_id, 0);
        chk("t1_to", resp_timeout, 0);
        tick(3);

        // MULT -3*5 from requester 1
        set_req(1, INST_MULT, 0, 0, 32'hFFFF_FFFD, 5);
        @(posedge clk); #2 r_valid[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("t3_elem_rs", elem_rs, 32'hFFFF_FFFD);
            chk("t3_elem_rt", elem_rt, 5);
            chk("t3_valid", resp_valid, (k == 3));
        end
        chk("t3_data", resp_data, 32'hFFFF_FFF1);
        chk("t3_id", resp_id, 1);
        tick(3);

        // Both requesters continuously valid with SUB
        set_req(0, INST_SUB, 0, 0, 100, 1);
        set_req(1, INST_SUB, 0, 0, 200, 2);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk); #1;
            acc = req_valid & req_ready;
            @(posedge clk); #2;
            if (acc != '0) begin
                g[ng] = acc[1] ? 1 : 0;
                r_rs[g[ng]] = r_rs[g[ng]] + 32'd11;
                ng++;
            end
        end
        r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        chk("t2_count", ng, 4);
        for (int k = 0; k < 4; k++) chk("t2_grant", g[k], k % 2);
        tick(6);

        // Response back-pressure with requester 0 pending
        resp_ready = 1'b0;
        set_req(0, INST_ADD, 0, 0, 10, 20);
        @(posedge clk); #2 set_req(0, INST_ADDI, 5, 0, 1, 0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("t4_valid", resp_valid, 1);
        chk("t4_data", resp_data, 30);
        repeat (5) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", resp_valid, 1);
            chk("t4_hold_data", resp_data, 30);
            chk("t4_hold_id", resp_id, 0);
            chk("t4_hold_ready", req_ready, 2'b00);
        end
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_hs_valid", resp_valid, 0);
        chk("t4_bubble_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        chk("t4_next_inst", elem_inst_num, INST_ADDI);
        chk("t4_next_const", elem_const16_x, 5);
        chk("t4_next_busy", elem_reset, 0);
        #1 r_valid[0] = 1'b0;
        tick(4);

        // Stuck element -> watchdog
        set_req(0, 6'd7, 0, 0, 9, 9);
        @(posedge clk); #2 r_valid[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("t5_wait_valid", resp_valid, 0);
            chk("t5_wait_elem_reset", elem_reset, 0);
        end
        @(posedge clk); #1;
        chk("t5_valid", resp_valid, 1);
        chk("t5_to", resp_timeout, 1);
        chk("t5_data", resp_data, 0);
        chk("t5_elem_reset", elem_reset, 1);
        tick(3);

        // DIV completing on the watchdog's last cycle: completion wins
        set_req(1, INST_DIV, 0, 0, 100, 7);
        @(posedge clk); #2 r_valid[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1 chk("t5b_wait_valid", resp_valid, 0);
        end
        @(posedge clk); #1;
        chk("t5b_valid", resp_valid, 1);
        chk("t5b_to", resp_timeout, 0);
        chk("t5b_data", resp_data, 14);
        tick(3);

        // Asynchronous reset in the middle of BUSY
        set_req(0, INST_ADD, 0, 0, 1, 2);
        set_req(1, INST_ADD, 0, 0, 5, 6);
        @(posedge clk);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("t6_valid", resp_valid, 0);
        chk("t6_elem_reset", elem_reset, 1);
        chk("t6_data", resp_data, 0);
        @(posedge clk); #2 reset = 1'b0;
        #3 chk("t6_first_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        chk("t6_first_id", resp_id, 0);
        chk("t6_first_rs", elem_rs, 1);
        #1 r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        tick(6);

        // Randomized traffic
        repeat (3000) begin
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (!r_valid[i] || (req_ready[i] === 1'b0 && acc[i])) begin
                    r_valid[i] = 1'b0;
                end
            end
            acc = '0;
            for (int i = 0; i < NR; i++) begin
                if (!r_valid[i] && $urandom_range(3) != 0) begin
                    set_req(i, 6'(ops_tbl[$urandom_range(21)]), $urandom, 5'($urandom),
                            $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(9)) : $urandom);
                end
            end
            resp_ready = ($urandom_range(2) != 0);
            @(negedge clk); #1;
            acc = req_valid & req_ready;
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) if (acc[i]) r_valid[i] = 1'b0;
        end
        r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        resp_ready = 1'b1;
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
